// File: rtl/tx_queue_cw_sched.sv
// Round-robin transmit-queue scheduler in front of the CSMA/CA backoff engine:
// picks a queue, supplies its contention-window exponent, launches TX, handles ACK/retry/drop.
module tx_queue_cw_sched #(
    parameter int NUM_QUEUE  = 4,
    parameter int TX_TIMEOUT = 20000,
    localparam int QW        = $clog2(NUM_QUEUE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_QUEUE-1:0]   queue_req,
    input  logic [4*NUM_QUEUE-1:0] cw_min_exp,
    input  logic [4*NUM_QUEUE-1:0] cw_max_exp,
    input  logic [3:0]             retry_limit,
    input  logic                   tx_allowed,
    input  logic                   tx_done,
    input  logic                   tx_ack_ok,
    output logic                   backoff_start,
    output logic [3:0]             cw_exp,
    output logic                   tx_start,
    output logic [QW-1:0]          tx_queue_idx,
    output logic                   queue_pop,
    output logic                   queue_drop,
    output logic                   tx_timeout,
    output logic [3:0]             retry_cnt,
    output logic                   busy
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_BACKOFF, S_TX} state_t;

    state_t         r_state, w_state_nxt;
    logic [3:0]     r_retry [NUM_QUEUE];
    logic [3:0]     w_retry_nxt [NUM_QUEUE];
    logic [QW-1:0]  r_rr_ptr, w_rr_nxt;
    logic [QW-1:0]  r_sel, w_sel_nxt;
    logic [3:0]     r_cw_exp, w_cw_nxt;
    logic [3:0]     r_retry_cnt, w_rc_nxt;
    logic [15:0]    r_wd, w_wd_nxt;
    logic           r_bo_first, w_bo_first_nxt;
    logic           r_backoff_start, w_bs_nxt;
    logic           r_tx_start, w_ts_nxt;
    logic           r_pop, w_pop_nxt;
    logic           r_drop, w_drop_nxt;
    logic           r_timeout, w_to_nxt;
    logic           r_busy;

    logic           w_arb_found;
    logic [QW-1:0]  w_arb_sel;
    logic [QW-1:0]  w_idx;
    logic [3:0]     w_min, w_max, w_cw;
    logic [4:0]     w_sum;
    logic [3:0]     w_sel_retry;
    logic           w_expire;

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_sel   = '0;
        w_idx       = '0;
        for (int i = 0; i < NUM_QUEUE; i++) begin
            w_idx = r_rr_ptr + QW'(i);
            if (!w_arb_found && queue_req[w_idx]) begin
                w_arb_found = 1'b1;
                w_arb_sel   = w_idx;
            end
        end
    end

    // Sum in 5 bits so min+retry cannot wrap before the clamp; min>max clamps to max.
    always_comb begin
        w_min = cw_min_exp[4*w_arb_sel +: 4];
        w_max = cw_max_exp[4*w_arb_sel +: 4];
        w_sum = {1'b0, w_min} + {1'b0, r_retry[w_arb_sel]};
        w_cw  = (w_sum > {1'b0, w_max}) ? w_max : w_sum[3:0];
    end

    assign w_sel_retry = r_retry[r_sel];
    assign w_expire    = (r_wd == 16'(TX_TIMEOUT - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_retry_nxt    = r_retry;
        w_rr_nxt       = r_rr_ptr;
        w_sel_nxt      = r_sel;
        w_cw_nxt       = r_cw_exp;
        w_rc_nxt       = r_retry_cnt;
        w_wd_nxt       = r_wd;
        w_bo_first_nxt = 1'b0;
        w_bs_nxt       = 1'b0;
        w_ts_nxt       = 1'b0;
        w_pop_nxt      = 1'b0;
        w_drop_nxt     = 1'b0;
        w_to_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|queue_req) w_state_nxt = S_ARB;
            end
            S_ARB: begin
                if (!w_arb_found) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_sel_nxt      = w_arb_sel;
                    w_cw_nxt       = w_cw;
                    w_rc_nxt       = r_retry[w_arb_sel];
                    w_bs_nxt       = 1'b1;
                    w_bo_first_nxt = 1'b1;
                    w_state_nxt    = S_BACKOFF;
                end
            end
            S_BACKOFF: begin
                // The engine is still loading cw_exp in the first cycle, so nothing is acted on yet.
                if (!r_bo_first) begin
                    if (!queue_req[r_sel]) begin
                        w_state_nxt = S_IDLE;
                    end else if (tx_allowed) begin
                        w_ts_nxt    = 1'b1;
                        w_wd_nxt    = '0;
                        w_state_nxt = S_TX;
                    end
                end
            end
            S_TX: begin
                w_wd_nxt = r_wd + 16'd1;
                if (tx_done && tx_ack_ok) begin
                    w_pop_nxt          = 1'b1;
                    w_retry_nxt[r_sel] = '0;
                    w_rr_nxt           = r_sel + QW'(1);
                    w_state_nxt        = S_IDLE;
                end else if (tx_done || w_expire) begin
                    w_to_nxt    = !tx_done;
                    w_state_nxt = S_IDLE;
                    if (w_sel_retry >= retry_limit) begin
                        w_pop_nxt          = 1'b1;
                        w_drop_nxt         = 1'b1;
                        w_retry_nxt[r_sel] = '0;
                        w_rr_nxt           = r_sel + QW'(1);
                    end else begin
                        w_retry_nxt[r_sel] = w_sel_retry + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            for (int q = 0; q < NUM_QUEUE; q++) r_retry[q] <= '0;
            r_rr_ptr        <= '0;
            r_sel           <= '0;
            r_cw_exp        <= '0;
            r_retry_cnt     <= '0;
            r_wd            <= '0;
            r_bo_first      <= 1'b0;
            r_backoff_start <= 1'b0;
            r_tx_start      <= 1'b0;
            r_pop           <= 1'b0;
            r_drop          <= 1'b0;
            r_timeout       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_retry         <= w_retry_nxt;
            r_rr_ptr        <= w_rr_nxt;
            r_sel           <= w_sel_nxt;
            r_cw_exp        <= w_cw_nxt;
            r_retry_cnt     <= w_rc_nxt;
            r_wd            <= w_wd_nxt;
            r_bo_first      <= w_bo_first_nxt;
            r_backoff_start <= w_bs_nxt;
            r_tx_start      <= w_ts_nxt;
            r_pop           <= w_pop_nxt;
            r_drop          <= w_drop_nxt;
            r_timeout       <= w_to_nxt;
            r_busy          <= (w_state_nxt != S_IDLE);
        end
    end

    assign backoff_start = r_backoff_start;
    assign cw_exp        = r_cw_exp;
    assign tx_start      = r_tx_start;
    assign tx_queue_idx  = r_sel;
    assign queue_pop     = r_pop;
    assign queue_drop    = r_drop;
    assign tx_timeout    = r_timeout;
    assign retry_cnt     = r_retry_cnt;
    assign busy          = r_busy;

endmodule
